// File: rtl/matmul_vedic_controller_if.sv
// matmul_vedic_controller_if: load and result handshake bundle of the matrix sequencer.
// Latency: none; wires only.
// Backpressure: load side is gated by inReady, result side is held until outReady.
// Signals: inValid/inReady/inData_A/inData_B (load beats), outValid/outReady/
//          outData_C/outRow/outCol (results), busy (sequencer not accepting loads).
interface matmul_vedic_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
);
  logic                  inValid;
  logic                  inReady;
  logic [DATA_WIDTH-1:0] inData_A;
  logic [DATA_WIDTH-1:0] inData_B;
  logic                  outValid;
  logic                  outReady;
  logic [ACC_WIDTH-1:0]  outData_C;
  logic [3:0]            outRow;
  logic [3:0]            outCol;
  logic                  busy;

  // Sequencer side.
  modport slave (
    input  inValid, inData_A, inData_B, outReady,
    output inReady, outValid, outData_C, outRow, outCol, busy
  );

  // Operand source / result consumer side.
  modport master (
    output inValid, inData_A, inData_B, outReady,
    input  inReady, outValid, outData_C, outRow, outCol, busy
  );
endinterface

// File: rtl/vedicmultiplier_8bit.sv
// vedicmultiplier_8bit: unsigned 8x8 multiplier built from 4-bit vertical/crosswise partials.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i (8-bit operands), p_o (16-bit product).
module vedicmultiplier_8bit (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [7:0] pp_ll, pp_lh, pp_hl, pp_hh;

  // Vertical (low*low, high*high) and crosswise (low*high, high*low) partials.
  assign pp_ll = {4'd0, a_i[3:0]} * {4'd0, b_i[3:0]};
  assign pp_lh = {4'd0, a_i[3:0]} * {4'd0, b_i[7:4]};
  assign pp_hl = {4'd0, a_i[7:4]} * {4'd0, b_i[3:0]};
  assign pp_hh = {4'd0, a_i[7:4]} * {4'd0, b_i[7:4]};

  // The vertical partials occupy disjoint byte lanes; crosswise terms land at bit 4.
  assign p_o = {pp_hh, pp_ll} + ({8'd0, pp_lh} << 4) + ({8'd0, pp_hl} << 4);
endmodule

// File: rtl/matmul_vedic_controller.sv
// matmul_vedic_controller: loads NxN matrices A and B, computes C = A x B on one shared multiplier.
// Latency: N*N load beats, then N+1 compute cycles plus at least one output cycle per element.
// Backpressure: inReady only in LOAD; each result is held on the bus until outReady.
// Ports: clk, rst (synchronous, active-high); bus = load port (inValid/inReady/inData_A/B),
//        result port (outValid/outReady/outData_C/outRow/outCol) and busy.
module matmul_vedic_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int MAT_DIM    = 2,
  parameter int ACC_WIDTH  = 20
) (
  input  logic clk,
  input  logic rst,
  matmul_vedic_controller_if.slave bus
);
  localparam int              NN        = MAT_DIM * MAT_DIM;
  localparam int              AW        = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [8:0]      DIM9      = 9'(MAT_DIM);
  localparam logic [3:0]      LAST_IDX  = 4'(MAT_DIM - 1);
  localparam logic [4:0]      K_END     = 5'(MAT_DIM);
  localparam logic [AW-1:0]   LAST_BEAT = AW'(NN - 1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_mem [NN];
  logic [DATA_WIDTH-1:0] b_mem [NN];
  logic [AW-1:0]         beat_q;
  logic [3:0]            i_q, j_q;
  logic [4:0]            k_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [15:0]           prod_q;
  logic [15:0]           mul_p;
  logic                  k_last, last_elem, load_fire;
  logic [3:0]            k_idx;
  logic [AW-1:0]         a_addr, b_addr;

  // k runs one step past N-1: that extra cycle only drains prod_q into acc_q,
  // so the operand index is parked at 0 to stay inside the register files.
  assign k_last    = (k_q == K_END);
  assign last_elem = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  assign k_idx     = k_last ? 4'd0 : k_q[3:0];
  assign a_addr    = AW'({5'd0, i_q} * DIM9 + {5'd0, k_idx});
  assign b_addr    = AW'({5'd0, k_idx} * DIM9 + {5'd0, j_q});
  assign load_fire = (state_q == S_LOAD) && bus.inValid;

  vedicmultiplier_8bit u_mul (
    .a_i (a_mem[a_addr]),
    .b_i (b_mem[b_addr]),
    .p_o (mul_p)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:    if (bus.inValid && beat_q == LAST_BEAT) state_d = S_COMPUTE;
      S_COMPUTE: if (k_last) state_d = S_OUTPUT;
      S_OUTPUT:  if (bus.outReady) state_d = last_elem ? S_LOAD : S_COMPUTE;
      default:   state_d = S_LOAD;
    endcase
  end

  // Outputs depend on registered state only.
  always_comb begin
    bus.inReady   = (state_q == S_LOAD);
    bus.outValid  = (state_q == S_OUTPUT);
    bus.busy      = (state_q != S_LOAD);
    bus.outData_C = acc_q;
    bus.outRow    = i_q;
    bus.outCol    = j_q;
  end

  // Operand register files; contents are fully rewritten by every load.
  always_ff @(posedge clk) begin
    if (!rst && load_fire) begin
      a_mem[beat_q] <= bus.inData_A;
      b_mem[beat_q] <= bus.inData_B;
    end
  end

  // Counters and multiply-accumulate datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (bus.inValid) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
        S_COMPUTE: begin
          k_q    <= k_last ? 5'd0 : k_q + 5'd1;
          prod_q <= mul_p;
          // First cycle clears; later cycles add the product registered one cycle earlier.
          if (k_q == 5'd0) acc_q <= '0;
          else             acc_q <= acc_q + ACC_WIDTH'(prod_q);
        end
        S_OUTPUT: begin
          if (bus.outReady) begin
            if (j_q == LAST_IDX) begin
              j_q <= '0;
              i_q <= last_elem ? 4'd0 : i_q + 4'd1;
            end else begin
              j_q <= j_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/matmul_vedic_controller.md
# matmul_vedic_controller

Sequencer that computes an unsigned MAT_DIM×MAT_DIM matrix product C = A×B by time-sharing one `vedicmultiplier_8bit` instance. Operand matrices stream in over a valid/ready load port. The block then runs a multiply-accumulate loop for each result element and streams C out over a valid/ready result port. It is the control layer between the operand source and the vedic multiplier datapath in the matrix-multiplier design.

## Interface
- DATA_WIDTH, 8: operand width. Fixed at 8 to match the `vedicmultiplier_8bit` instance.
- MAT_DIM, 2: matrix dimension N. Legal range is 2..16.
- ACC_WIDTH, 20: accumulator and result width. Must be ≥ 2*DATA_WIDTH + clog2(MAT_DIM).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- inValid  input  1  the load beat on inData_A/inData_B is valid.
- inReady  output  1  the block accepts load beats.
- inData_A  input  DATA_WIDTH  element of A, row-major order.
- inData_B  input  DATA_WIDTH  element of B, row-major order, same beat index as A.
- outValid  output  1  outData_C, outRow and outCol hold a valid result.
- outReady  input  1  the consumer accepts the result.
- outData_C  output  ACC_WIDTH  result element C[outRow][outCol].
- outRow  output  4  row index of the result.
- outCol  output  4  column index of the result.
- busy  output  1  high in the COMPUTE and OUTPUT states.

## Operation
- **States:** LOAD, COMPUTE, OUTPUT. The reset state is LOAD.
- **LOAD:**
  - inReady=1.
  - Each cycle with inValid&&inReady writes A[beat] and B[beat] into internal register files.
  - beat counts 0..N²-1; beat = row*N + col.
  - Cycles with inValid=0 are gaps: no write, no count.
  - On acceptance of beat N²-1, go to COMPUTE with element index (i,j)=(0,0).
- **COMPUTE, one result element:**
  - Counter k runs 0..N-1.
  - Each cycle the multiplier is driven with A[i][k] and B[k][j]; its 16-bit product is registered into prodReg.
  - The accumulator clears on the first cycle of each element.
  - Each cycle after a product has been registered, acc += prodReg, zero-extended to ACC_WIDTH.
  - After the last accumulate, the element takes exactly N+1 cycles; go to OUTPUT.
- **OUTPUT:**
  - outValid=1; outData_C=acc; outRow=i; outCol=j.
  - All outputs are held stable while outReady=0.
  - On the outValid&&outReady cycle:
    - If (i,j)=(N-1,N-1), go to LOAD.
    - Otherwise advance (i,j) in row-major order (j first, wrapping into i) and go to COMPUTE.
- **Arithmetic:** unsigned only. With legal ACC_WIDTH no overflow is possible; otherwise the sum wraps modulo 2^ACC_WIDTH.
- **Ignored inputs:** inValid outside LOAD, and outReady outside OUTPUT.
- **Reset:**
  - rst high on any edge returns to LOAD, clears all counters, acc and prodReg, and discards partial loads and results.
  - A new load restarts at beat 0.
  - Register-file contents need not be cleared; they are fully overwritten before use.

## Timing
- **Values after any reset edge:** inReady=1, outValid=0, outData_C=0, outRow=0, outCol=0, busy=0.
- **LOAD to COMPUTE:** the edge accepting beat N²-1 enters COMPUTE; busy=1 and inReady=0 in the next cycle.
- **COMPUTE to OUTPUT:** COMPUTE is entered at edge E; outValid=1 in the cycle after edge E+N+1. For N=2, that is 3 COMPUTE cycles, then OUTPUT.
- **After a result handshake:** outValid=0 in the next cycle. There are no back-to-back outValid cycles across elements.
- **Best-case frame:** N² load cycles + N²·(N+2) cycles. For N=2 this is 4+16=20 cycles.
- **Handshake outputs:** inReady and outValid are pure functions of the registered state. There is no combinational path from inValid or outReady.

## Test plan
- **Basic product:**
  - Load A=[1,2,3,4], B=[5,6,7,8] with no gaps; hold outReady=1.
  - Required: results (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50, in that order.
  - Required: inReady returns high 16 cycles after the last load beat.
- **Max operands:**
  - All A and B elements = 255.
  - Required: every result is 130050, with no wrap at ACC_WIDTH=20.
- **Backpressure:**
  - Hold outReady=0 for 5 cycles on element (0,1) of the basic case.
  - Required: outValid stays 1, and outData_C=22, outRow=0, outCol=1 stay stable.
  - Required: the next result is 43 once outReady is released.
- **Load gaps:**
  - Insert inValid=0 between every beat of the basic case.
  - Required: identical results; inReady stays 1 throughout LOAD.
- **Reset mid-operation:**
  - Assert rst for 1 cycle during COMPUTE of element (1,0).
  - Required: next cycle shows inReady=1, outValid=0, busy=0.
  - Reload with A=identity, B=[9,8,7,6]; required results are 9, 8, 7, 6.
- **MAT_DIM=3 build:**
  - A=1..9, B=identity.
  - Required: outputs 1..9 in row-major order, each element taking 4 COMPUTE cycles.
